// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down counter with programmable modulus,
// wrap/saturate mode, synchronous clear/load, a registered wrap pulse and
// sticky overflow/underflow flags.
// Optional prescaler enabled by defining UDCNT_PRESCALE_EN (adds the presc port).
module updown_counter_mod #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  E,
    input  logic                  D,
    input  logic                  sat,
    input  logic [WIDTH-1:0]      max_val,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clr,
    input  logic                  clr_flags,
`ifdef UDCNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  wrap,
    output logic                  ovf,
    output logic                  unf,
    output logic                  at_max,
    output logic                  at_zero
);

    logic             tick_hit;
    logic             step;
    logic [WIDTH-1:0] count_nx;
    logic             wrap_nx;
    logic             ovf_ev;
    logic             unf_ev;

`ifdef UDCNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] tick;

    assign tick_hit = (tick == presc);

    // Prescaler: counts enabled cycles, restarts on reset/clear/load or on a hit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick <= '0;
        end else if (clr || load) begin
            tick <= '0;
        end else if (E) begin
            if (tick_hit) tick <= '0;
            else          tick <= tick + 1'b1;
        end
    end
`else
    // Without the prescaler every enabled cycle is a step; the constant
    // comparison keeps PRESCALE_W referenced in this build.
    assign tick_hit = (PRESCALE_W > 0);
`endif

    assign at_max  = (count >= max_val);
    assign at_zero = (count == '0);
    assign step    = E && !clr && !load && tick_hit;

    // Next-count selection: clear beats load beats step; boundary events flagged here
    always_comb begin
        count_nx = count;
        wrap_nx  = 1'b0;
        ovf_ev   = 1'b0;
        unf_ev   = 1'b0;
        if (clr) begin
            count_nx = '0;
        end else if (load) begin
            count_nx = (load_val > max_val) ? max_val : load_val;
        end else if (step) begin
            if (!D) begin
                if (at_max) begin
                    ovf_ev = 1'b1;
                    if (sat) begin
                        count_nx = max_val;
                    end else begin
                        count_nx = '0;
                        wrap_nx  = 1'b1;
                    end
                end else begin
                    count_nx = count + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    unf_ev = 1'b1;
                    if (sat) begin
                        count_nx = '0;
                    end else begin
                        count_nx = max_val;
                        wrap_nx  = 1'b1;
                    end
                end else begin
                    count_nx = count - 1'b1;
                end
            end
        end
    end

    // Registered count, wrap pulse and sticky flags (a flag event beats clr_flags)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_nx;
            wrap  <= wrap_nx;
            if (ovf_ev)         ovf <= 1'b1;
            else if (clr_flags) ovf <= 1'b0;
            if (unf_ev)         unf <= 1'b1;
            else if (clr_flags) unf <= 1'b0;
        end
    end

endmodule
